// File: rtl/relu_pool_if.sv
// relu_pool_if: control, input stream and output stream bundle for relu_pool_stream
interface relu_pool_if #(
  parameter int CHANNELS = 16,
  parameter int DATA_W = 18
);
  logic start, relu_en, pool_en, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [CHANNELS*DATA_W-1:0] in_data, out_data;
  modport master (
    output start, relu_en, pool_en, in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_last, busy, done
  );
  modport slave (
    input start, relu_en, pool_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/relu_pool_stream.sv
// relu_pool_stream: per-channel ReLU with optional 2x2/stride-2 signed max-pool over a raster-order frame
module relu_pool_stream #(
  parameter int WIDTH = 28,
  parameter int HEIGHT = 28,
  parameter int CHANNELS = 16,
  parameter int DATA_W = 18
) (
  input logic clk,
  input logic rst,
  relu_pool_if.slave s
);
  localparam int PW = CHANNELS * DATA_W;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int LW = WIDTH > 2 ? $clog2(WIDTH / 2) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic relu_q, pool_q, fin, out_valid, out_last;
  logic fire, out_fire, produce, last_in, last_col;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [LW-1:0] lx;
  logic [PW-1:0] pix, hreg, result, out_data;
  logic [PW-1:0] linebuf [WIDTH/2];

  function automatic logic [PW-1:0] vmax(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    for (int k = 0; k < CHANNELS; k++)
      r[k*DATA_W +: DATA_W] = $signed(a[k*DATA_W +: DATA_W]) > $signed(b[k*DATA_W +: DATA_W])
                              ? a[k*DATA_W +: DATA_W] : b[k*DATA_W +: DATA_W];
    return r;
  endfunction

  assign lx = LW'(x >> 1);
  assign fire = s.in_valid && s.in_ready;
  assign out_fire = out_valid && s.out_ready;
  assign last_col = x == XW'(WIDTH - 1);
  assign last_in = last_col && y == YW'(HEIGHT - 1);
  assign produce = !pool_q || (x[0] && y[0]);
  assign result = pool_q ? vmax(vmax(linebuf[lx], hreg), pix) : pix;
  assign s.in_ready = state == RUN && !fin && (!out_valid || s.out_ready);
  assign s.out_valid = out_valid;
  assign s.out_data = out_data;
  assign s.out_last = out_last;
  assign s.busy = state == RUN;
  assign s.done = state == DONE;

  always_comb begin
    pix = s.in_data;
    for (int k = 0; k < CHANNELS; k++)
      pix[k*DATA_W +: DATA_W] = relu_q && s.in_data[k*DATA_W + DATA_W - 1] ? '0 : s.in_data[k*DATA_W +: DATA_W];
  end

  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (s.start ? RUN : IDLE) :
              state == RUN ? (out_fire && out_last ? DONE : RUN) : IDLE;
  end

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;

  // fin blocks further input once the last pixel is in, until the next start
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      fin <= 1'b0;
      relu_q <= 1'b0;
      pool_q <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      if (state == IDLE && s.start) begin
        x <= '0;
        y <= '0;
        fin <= 1'b0;
        relu_q <= s.relu_en;
        pool_q <= s.pool_en;
      end else if (fire) begin
        x <= last_col ? '0 : x + 1'b1;
        y <= last_col && !last_in ? y + 1'b1 : y;
        fin <= last_in;
      end
      if (fire && produce) begin
        out_valid <= 1'b1;
        out_data <= result;
        out_last <= last_in;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

  // even column seeds the row pair; odd column of an even row parks the horizontal max
  always_ff @(posedge clk)
    if (fire && pool_q) begin
      if (!x[0]) hreg <= pix;
      else if (!y[0]) linebuf[lx] <= vmax(hreg, pix);
    end
endmodule

// File: tb/tb_relu_pool_stream.sv
// tb_relu_pool_stream: randomized frames checked against a whole-frame ReLU/max-pool reference
module tb_relu_pool_stream;
  localparam int W = 4, H = 4, C = 2, D = 18, N = W * H, PW = C * D;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  relu_pool_if #(.CHANNELS(C), .DATA_W(D)) bus ();
  relu_pool_stream #(.WIDTH(W), .HEIGHT(H), .CHANNELS(C), .DATA_W(D)) dut (.clk(clk), .rst(rst), .s(bus));

  int compared = 0, mismatched = 0;
  logic [PW-1:0] pix [N];
  logic [PW-1:0] expq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [D-1:0] chv(input int i, input int k, input bit relu);
    logic signed [D-1:0] v;
    v = pix[i][k*D +: D];
    return (relu && v < 0) ? '0 : v;
  endfunction

  function automatic void build(input bit relu, input bit pool);
    logic [PW-1:0] o;
    logic signed [D-1:0] m;
    expq.delete();
    if (!pool) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < C; k++) o[k*D +: D] = chv(i, k, relu);
        expq.push_back(o);
      end
    end else begin
      for (int oy = 0; oy < H / 2; oy++)
        for (int ox = 0; ox < W / 2; ox++) begin
          for (int k = 0; k < C; k++) begin
            m = chv(2 * oy * W + 2 * ox, k, relu);
            for (int dy = 0; dy < 2; dy++)
              for (int dx = 0; dx < 2; dx++)
                if (chv((2 * oy + dy) * W + 2 * ox + dx, k, relu) > m)
                  m = chv((2 * oy + dy) * W + 2 * ox + dx, k, relu);
            o[k*D +: D] = m;
          end
          expq.push_back(o);
        end
    end
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < N; i++) pix[i] = PW'({$urandom(), $urandom()});
  endtask

  task automatic fill_seq();
    fill_rand();
    for (int i = 0; i < N; i++) pix[i][D-1:0] = D'(i + 1);
  endtask

  task automatic begin_frame(input bit relu, input bit pool);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.relu_en = relu; bus.pool_en = pool;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.relu_en = ~relu; bus.pool_en = ~pool;
    check("busy_after_start", bus.busy, 1);
    build(relu, pool);
  endtask

  task automatic stream(input int vp, input int rp, input bit stall, input bit poke);
    int idx, got, extra, stalled, last_c, n;
    bit seen_done, pv, hold;
    idx = 0; got = 0; extra = 0; stalled = 0; last_c = -10; n = expq.size();
    seen_done = 0; pv = 0;
    for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
      @(posedge clk); #1;
      if (pv) check("hold_valid", bus.out_valid, 1);
      if (bus.done) begin
        seen_done = 1;
        check("done_timing", cyc, last_c + 1);
        check("done_no_valid", bus.out_valid, 0);
        check("done_not_busy", bus.busy, 0);
      end
      if (bus.out_valid && got < n) begin
        check("out_data", bus.out_data, expq[got]);
        check("out_last", bus.out_last, got == n - 1);
      end
      hold = stall && got == 0 && bus.out_valid && stalled < 5;
      if (hold) stalled++;
      bus.start = poke && cyc == 3;
      bus.in_valid = idx < N ? int'($urandom_range(99)) < vp : 1'b1;
      bus.in_data = idx < N ? pix[idx] : PW'($urandom());
      bus.out_ready = hold ? 1'b0 : int'($urandom_range(99)) < rp;
      #1;
      if (hold) check("stall_in_ready", bus.in_ready, 0);
      if (vp == 100 && rp == 100 && !stall && idx < N && bus.busy) check("full_rate", bus.in_ready, 1);
      pv = bus.out_valid && !bus.out_ready;
      if (bus.out_valid && bus.out_ready) begin
        if (got >= n) check("out_overflow", got, n - 1);
        if (bus.out_last) last_c = cyc;
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (idx < N) idx++;
        else extra++;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b0;
    check("done_seen", seen_done, 1);
    check("out_count", got, n);
    check("in_count", idx, N);
    check("no_extra_in", extra, 0);
    if (stall) check("stall_cycles", stalled, 5);
  endtask

  initial begin
    int k;
    bus.start = 0; bus.relu_en = 0; bus.pool_en = 0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;

    fill_seq();
    begin_frame(1, 1);
    stream(100, 100, 0, 0);

    fill_rand();
    pix[0][D-1:0] = D'(-5); pix[1][D-1:0] = '0; pix[2][D-1:0] = D'(7); pix[3][D-1:0] = 18'h20000;
    begin_frame(1, 0);
    stream(70, 70, 0, 0);

    fill_rand();
    pix[0][D-1:0] = D'(-3); pix[1][D-1:0] = D'(-1); pix[4][D-1:0] = D'(-8); pix[5][D-1:0] = D'(-2);
    begin_frame(0, 1);
    stream(80, 60, 0, 0);

    fill_rand();
    begin_frame(1, 1);
    stream(100, 100, 1, 0);

    fill_rand();
    begin_frame(0, 0);
    k = 0;
    for (int g = 0; g < 50 && k < 7; g++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = pix[k]; bus.out_ready = 1'b1;
      #1;
      if (bus.in_ready) k++;
    end
    check("abort_beats", k, 7);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    for (int g = 0; g < 3; g++) begin
      check("abort_no_done", bus.done, 0);
      @(posedge clk); #1;
    end
    fill_seq();
    begin_frame(1, 1);
    stream(100, 100, 0, 0);

    fill_rand();
    begin_frame(1, 0);
    stream(90, 90, 0, 1);

    for (int f = 0; f < 4; f++) begin
      fill_rand();
      begin_frame(1'($urandom_range(1)), 1'($urandom_range(1)));
      stream(50, 50, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/relu_pool_stream.md
RELU_POOL_STREAM -- requirements
Module: relu_pool_stream

Interface
REQ-001 Parameters (name, default, meaning):
- WIDTH, 28, input feature-map columns; even, >=2.
- HEIGHT, 28, input feature-map rows; even, >=2.
- CHANNELS, 16, channels carried in parallel per beat.
- DATA_W, 18, signed two's-complement bits per channel.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, frame start pulse.
- relu_en, in, 1, ReLU enable; sampled at start.
- pool_en, in, 1, 2x2 max-pool enable (0 = pass-through); sampled at start.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted when in_valid and in_ready are both 1.
- in_data, in, CHANNELS*DATA_W, one pixel; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream ready.
- out_data, out, CHANNELS*DATA_W, one output pixel; same packing as in_data.
- out_last, out, 1, marks the final output beat of the frame.
- busy, out, 1, high in RUN.
- done, out, 1, one-cycle pulse at frame completion.

Function
REQ-003 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start.
- RUN->DONE on the handshake of the out_last beat.
- DONE->IDLE unconditionally after one cycle.

REQ-004 start outside IDLE is ignored. relu_en and pool_en are latched on the start cycle and held for the whole frame.

REQ-005 On start, counters x=0 and y=0 and the frame beat count are cleared. Input is raster order, x fastest, WIDTH*HEIGHT beats per frame.

REQ-006 in_ready = (state==RUN) and (!out_valid or out_ready). No input is accepted in IDLE or DONE.

REQ-007 ReLU applies per channel to each accepted beat: if relu_en and the value is negative (MSB=1), it becomes 0; otherwise unchanged.

REQ-008 All maximum comparisons are signed over DATA_W bits. Output width equals input width; there is no saturation or rounding.

REQ-009 pool_en=0 (pass-through): each accepted beat produces one output beat carrying the ReLU'd pixel. The frame has WIDTH*HEIGHT outputs.

REQ-010 pool_en=1, 2x2 window with stride 2. Per accepted pixel p at (y,x):
- y even, x even: hreg = p.
- y even, x odd: linebuf[x/2] = max(hreg, p).
- y odd, x even: hreg = p.
- y odd, x odd: output max(linebuf[x/2], hreg, p).
- Frame outputs: (HEIGHT/2)*(WIDTH/2).

REQ-011 Line buffer depth is WIDTH/2 entries of CHANNELS*DATA_W bits. Registers or inferred RAM are both acceptable; a read and a write of the same entry never occur in one cycle.

REQ-012 Output register timing: out_data, out_valid and out_last are registered and asserted the cycle after the producing input handshake (latency 1). They are held stable until out_valid and out_ready are both 1.

REQ-013 out_valid clears on the output handshake unless a new producing beat is accepted in the same cycle. In that case it stays 1 with the new data, giving full throughput of one beat per cycle.

REQ-014 out_last=1 only on the final output beat: (y,x) = (HEIGHT-1, WIDTH-1).

REQ-015 Counter wrap: x wraps WIDTH-1 -> 0 with y incrementing. After (HEIGHT-1, WIDTH-1), no further input is accepted until the next start.

REQ-016 done=1 for exactly the one cycle in DONE. busy=1 exactly while in RUN.

REQ-017 in_valid while in_ready=0 has no effect. in_data must not be consumed or counted.

Reset
REQ-018 rst forces, on the next edge:
- state IDLE;
- x, y and beat counters to 0;
- out_valid, out_last, done, busy and in_ready to 0;
- out_data to 0;
- latched relu_en and pool_en to 0.

REQ-019 rst mid-frame aborts the frame, discards any pending output, and produces no done. The next start begins a clean frame.

REQ-020 Line buffer and hreg contents need no reset. They are fully overwritten before use in every frame.

Verification
REQ-021 Bench runs WIDTH=4, HEIGHT=4, CHANNELS=2, DATA_W=18 unless stated otherwise.
- Pool, ReLU on, channel 0 pixels 1..16 raster: 4 outputs 6,8,14,16, out_last on the 4th, done one cycle later.
- ReLU on, pool off, input -5, 0, 7 and 0x20000: outputs 0, 0, 7 and 0.
- ReLU off, pool on, 2x2 window -3, -1, -8, -2: output -1 (0x3FFFF).
- Pool on, out_ready held 0 for 5 cycles while the first output is valid: out_data stable, in_ready=0, no beats lost; continuous in_valid/out_ready afterwards gives 1 beat/cycle.
- rst asserted after 7 input beats: next cycle out_valid=0, busy=0, no done; a restart with pixels 1..16 yields 6,8,14,16.
- start asserted while busy: ignored; beat count and outputs unchanged.
